// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode-class helper for the
// multi-cycle ALU and its iterative mul/div core.
package alu_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_SUM    = 5'b00010;
  localparam logic [4:0] OP_EQUAL  = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_XOR    = 5'b01000;
  localparam logic [4:0] OP_NOR    = 5'b01001;
  localparam logic [4:0] OP_SUB    = 5'b01010;
  localparam logic [4:0] OP_GE     = 5'b01100;
  localparam logic [4:0] OP_GEU    = 5'b01101;
  localparam logic [4:0] OP_SLT    = 5'b01110;
  localparam logic [4:0] OP_SLTU   = 5'b01111;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // True only for the eight defined M-extension codes (10xxx).
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M-style multiply/divide core: one multiplier/quotient bit
// per cycle over operand magnitudes, sign fix-up folded into the last cycle.
module alu_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              bzero_q, bzero_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              a_signed, b_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    mag_a    = (a_signed && a[XLEN-1]) ? -a : a;
    mag_b    = (b_signed && b[XLEN-1]) ? -b : b;

    // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (op_q[2]) begin
      if (diff[XLEN]) step = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else            step = {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {sum, acc_q[XLEN-1:1]};
    end

    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    bzero_d = bzero_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      op_d    = op;
      neg_a_d = a_signed & a[XLEN-1];
      neg_b_d = b_signed & b[XLEN-1];
      bzero_d = (b == '0);
      dvs_d   = mag_b;
      acc_d   = {{XLEN{1'b0}}, mag_a};
    end else if (busy_q) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN - 1)) busy_d = 1'b0;
    end

    // Result is taken from the final step directly so the top can latch it
    // on the same edge that retires the last iteration.
    done     = busy_q && (cnt_q == CW'(XLEN - 1));
    prod_fix = (neg_a_q ^ neg_b_q) ? -step : step;
    quo      = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (bzero_q)                     result = '1;
        else if (neg_a_q ^ neg_b_q)      result = -quo;
        else                             result = quo;
      end
      default:                result = neg_a_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bzero_q <= 1'b0;
      dvs_q   <= '0;
      acc_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      bzero_q <= bzero_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: legacy ops in one cycle, M-extension ops
// through the iterative core, valid/ready on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            VALID_i,
  output logic            READY_o,
  input  logic [4:0]      ALU_OP_i,
  input  logic [XLEN-1:0] ALU_RS1_i,
  input  logic [XLEN-1:0] ALU_RS2_i,
  output logic            VALID_o,
  input  logic            READY_i,
  output logic [XLEN-1:0] ALU_RD_o,
  output logic            ALU_ZR_o,
  output logic            ILL_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            zr_q, zr_d;
  logic            ill_q, ill_d;

  logic [XLEN-1:0] legacy_res;
  logic            legacy_ill;
  logic [SHW-1:0]  sh;
  logic            md_start, md_done;
  logic [XLEN-1:0] md_result;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (md_start),
    .op     (ALU_OP_i[2:0]),
    .a      (ALU_RS1_i),
    .b      (ALU_RS2_i),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    sh         = ALU_RS2_i[SHW-1:0];
    legacy_res = '0;
    legacy_ill = 1'b0;
    case (ALU_OP_i)
      OP_AND:   legacy_res = ALU_RS1_i & ALU_RS2_i;
      OP_OR:    legacy_res = ALU_RS1_i | ALU_RS2_i;
      OP_SUM:   legacy_res = ALU_RS1_i + ALU_RS2_i;
      OP_EQUAL: legacy_res[0] = (ALU_RS1_i == ALU_RS2_i);
      OP_SLL:   legacy_res = ALU_RS1_i << sh;
      OP_SRL:   legacy_res = ALU_RS1_i >> sh;
      OP_SRA:   legacy_res = $signed(ALU_RS1_i) >>> sh;
      OP_XOR:   legacy_res = ALU_RS1_i ^ ALU_RS2_i;
      OP_NOR:   legacy_res = ~(ALU_RS1_i | ALU_RS2_i);
      OP_SUB:   legacy_res = ALU_RS1_i - ALU_RS2_i;
      OP_GE:    legacy_res[0] = ($signed(ALU_RS1_i) >= $signed(ALU_RS2_i));
      OP_GEU:   legacy_res[0] = (ALU_RS1_i >= ALU_RS2_i);
      OP_SLT:   legacy_res[0] = ($signed(ALU_RS1_i) < $signed(ALU_RS2_i));
      OP_SLTU:  legacy_res[0] = (ALU_RS1_i < ALU_RS2_i);
      // Unused legacy codes and every code with bit4 set land here; M ops
      // are diverted to the core before this result is used.
      default:  legacy_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (VALID_i) begin
          if (is_muldiv(ALU_OP_i) && MULDIV_EN) begin
            md_start = 1'b1;
            state_d  = BUSY;
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
            rd_d    = legacy_ill ? '0 : legacy_res;
            ill_d   = legacy_ill;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = DONE;
          valid_d = 1'b1;
          rd_d    = md_result;
          ill_d   = 1'b0;
        end
      end
      DONE: begin
        if (READY_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    zr_d = (rd_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rd_q    <= '0;
      zr_q    <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      zr_q    <= zr_d;
      ill_q   <= ill_d;
    end
  end

  assign READY_o  = (state_q == IDLE);
  assign VALID_o  = valid_q;
  assign ALU_RD_o = rd_q;
  assign ALU_ZR_o = zr_q;
  assign ILL_o    = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors plus randomized ops
// against an arithmetic reference model, across three parameterisations.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  op;
  logic [31:0] rs1, rs2;
  logic        rdy_i;
  logic        v32, vnm, v16;

  logic        rdy32, val32, zr32, ill32;
  logic [31:0] rd32;
  logic        rdynm, valnm, zrnm, illnm;
  logic [31:0] rdnm;
  logic        rdy16, val16, zr16, ill16;
  logic [15:0] rd16;

  int checks = 0;
  int errors = 0;

  alu_mc #(.XLEN(32), .MULDIV_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .VALID_i(v32), .READY_o(rdy32), .ALU_OP_i(op),
    .ALU_RS1_i(rs1), .ALU_RS2_i(rs2), .VALID_o(val32), .READY_i(rdy_i),
    .ALU_RD_o(rd32), .ALU_ZR_o(zr32), .ILL_o(ill32));

  alu_mc #(.XLEN(32), .MULDIV_EN(1'b0)) u_nomd (
    .clk_i(clk), .rst_i(rst), .VALID_i(vnm), .READY_o(rdynm), .ALU_OP_i(op),
    .ALU_RS1_i(rs1), .ALU_RS2_i(rs2), .VALID_o(valnm), .READY_i(rdy_i),
    .ALU_RD_o(rdnm), .ALU_ZR_o(zrnm), .ILL_o(illnm));

  alu_mc #(.XLEN(16), .MULDIV_EN(1'b1)) u_x16 (
    .clk_i(clk), .rst_i(rst), .VALID_i(v16), .READY_o(rdy16), .ALU_OP_i(op),
    .ALU_RS1_i(rs1[15:0]), .ALU_RS2_i(rs2[15:0]), .VALID_o(val16), .READY_i(rdy_i),
    .ALU_RD_o(rd16), .ALU_ZR_o(zr16), .ILL_o(ill16));

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Reference: returns {illegal, result}; plain integer arithmetic on xlen bits.
  function automatic logic [32:0] model(input int xlen, input logic [4:0] o,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input bit md_en);
    longint mask, ua, ub, sa, sb, r, half;
    int sh;
    bit ill;
    mask = (longint'(1) << xlen) - 1;
    half = longint'(1) << (xlen - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (longint'(1) << xlen) : ua;
    sb   = (ub >= half) ? ub - (longint'(1) << xlen) : ub;
    sh   = int'(ub % xlen);
    ill  = 1'b0;
    r    = 0;
    case (o)
      5'd0:  r = ua & ub;
      5'd1:  r = ua | ub;
      5'd2:  r = ua + ub;
      5'd3:  r = longint'(ua == ub);
      5'd4:  r = ua << sh;
      5'd5:  r = ua >> sh;
      5'd7:  r = sa >>> sh;
      5'd8:  r = ua ^ ub;
      5'd9:  r = ~(ua | ub);
      5'd10: r = ua - ub;
      5'd12: r = longint'(sa >= sb);
      5'd13: r = longint'(ua >= ub);
      5'd14: r = longint'(sa < sb);
      5'd15: r = longint'(ua < ub);
      5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23: begin
        if (!md_en) ill = 1'b1;
        else case (o)
          5'd16: r = ua * ub;
          5'd17: r = (sa * sb) >> xlen;
          5'd18: r = (sa * ub) >> xlen;
          5'd19: r = (ua * ub) >> xlen;
          5'd20: r = (ub == 0) ? mask : sa / sb;
          5'd21: r = (ub == 0) ? mask : ua / ub;
          5'd22: r = (ub == 0) ? sa : sa % sb;
          default: r = (ub == 0) ? ua : ua % ub;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) r = 0;
    r = r & mask;
    return {ill, r[31:0]};
  endfunction

  function automatic logic cur_ready(input int sel);
    case (sel)
      0: return rdy32;
      1: return rdynm;
      default: return rdy16;
    endcase
  endfunction

  function automatic logic cur_valid(input int sel);
    case (sel)
      0: return val32;
      1: return valnm;
      default: return val16;
    endcase
  endfunction

  // Issue one op on the selected instance; reports result, flags and the
  // latency in cycles from the accept edge (1 = valid right after accept).
  task automatic do_op(input int sel, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] rd, output logic zr,
                       output logic ill, output int lat, output bit busy_ok);
    int guard = 0;
    while (!cur_ready(sel) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    op = o; rs1 = a; rs2 = b;
    case (sel)
      0: v32 = 1'b1;
      1: vnm = 1'b1;
      default: v16 = 1'b1;
    endcase
    @(posedge clk); #1;
    v32 = 1'b0; vnm = 1'b0; v16 = 1'b0;
    op = 5'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (!cur_valid(sel) && lat < 100) begin
      if (cur_ready(sel)) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    case (sel)
      0: begin rd = rd32; zr = zr32; ill = ill32; end
      1: begin rd = rdnm; zr = zrnm; ill = illnm; end
      default: begin rd = {16'h0, rd16}; zr = zr16; ill = ill16; end
    endcase
    if (rdy_i) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({val32, rd32, zr32, ill32, rdy32} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b rd=%h zr=%b ill=%b rdy=%b want v=0 rd=0 zr=1 ill=0 rdy=1",
               val32, rd32, zr32, ill32, rdy32);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_legacy_directed();
    logic [4:0]  ops [4] = '{5'b00010, 5'b01010, 5'b00111, 5'b00100};
    logic [31:0] as  [4] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h00000001};
    logic [31:0] bs  [4] = '{32'h1, 32'd5, 32'd4, 32'd33};
    logic [31:0] ex  [4] = '{32'h80000000, 32'h0, 32'hF8000000, 32'h00000002};
    logic [31:0] rd; logic zr, ill; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      do_op(0, ops[i], as[i], bs[i], rd, zr, ill, lat, bok);
      checks++;
      if ({rd, zr, ill} !== {ex[i], ex[i] == 32'h0, 1'b0} || lat != 1) begin
        errors++;
        $display("FAIL legacy_dir[%0d] got rd=%h zr=%b ill=%b lat=%0d want rd=%h zr=%b ill=0 lat=1",
                 i, rd, zr, ill, lat, ex[i], ex[i] == 32'h0);
      end
    end
  endtask

  task automatic test_legacy_random();
    logic [31:0] rd, a, b; logic zr, ill; int lat; bit bok;
    logic [4:0] o; logic [32:0] m;
    for (int i = 0; i < 40; i++) begin
      o = 5'($urandom_range(0, 15));
      a = $urandom; b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      m = model(32, o, a, b, 1'b1);
      do_op(0, o, a, b, rd, zr, ill, lat, bok);
      checks++;
      if ({ill, zr, rd} !== {m[32], m[31:0] == 32'h0, m[31:0]} || lat != 1) begin
        errors++;
        $display("FAIL legacy_rand op=%b a=%h b=%h got rd=%h zr=%b ill=%b lat=%0d want rd=%h ill=%b lat=1",
                 o, a, b, rd, zr, ill, lat, m[31:0], m[32]);
      end
    end
  endtask

  task automatic test_muldiv_directed();
    logic [4:0]  ops [10] = '{5'b10000, 5'b10011, 5'b10001, 5'b10010, 5'b10100,
                              5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110};
    logic [31:0] as  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd2, 32'd2,
                              32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex  [10] = '{32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0};
    logic [31:0] rd; logic zr, ill; int lat; bit bok;
    for (int i = 0; i < 10; i++) begin
      do_op(0, ops[i], as[i], bs[i], rd, zr, ill, lat, bok);
      checks++;
      if ({rd, zr, ill} !== {ex[i], ex[i] == 32'h0, 1'b0} || lat != 33 || !bok) begin
        errors++;
        $display("FAIL muldiv_dir[%0d] got rd=%h zr=%b ill=%b lat=%0d rdy_low=%b want rd=%h ill=0 lat=33 rdy_low=1",
                 i, rd, zr, ill, lat, bok, ex[i]);
      end
    end
  endtask

  task automatic test_muldiv_random();
    logic [31:0] rd, a, b; logic zr, ill; int lat; bit bok;
    logic [4:0] o; logic [32:0] m;
    for (int i = 0; i < 24; i++) begin
      o = 5'($urandom_range(16, 23));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      m = model(32, o, a, b, 1'b1);
      do_op(0, o, a, b, rd, zr, ill, lat, bok);
      checks++;
      if ({ill, zr, rd} !== {m[32], m[31:0] == 32'h0, m[31:0]} || lat != 33 || !bok) begin
        errors++;
        $display("FAIL muldiv_rand op=%b a=%h b=%h got rd=%h zr=%b ill=%b lat=%0d want rd=%h ill=%b lat=33",
                 o, a, b, rd, zr, ill, lat, m[31:0], m[32]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic zr, ill; int lat; bit bok;
    rdy_i = 1'b0;
    do_op(0, 5'b01010, 32'd9, 32'd4, rd, zr, ill, lat, bok);
    checks++;
    if ({rd, zr, ill} !== {32'd5, 1'b0, 1'b0} || lat != 1) begin
      errors++;
      $display("FAIL bp_result got rd=%h zr=%b ill=%b lat=%0d want rd=5 zr=0 ill=0 lat=1", rd, zr, ill, lat);
    end
    for (int i = 0; i < 10; i++) begin
      op = 5'b00010; rs1 = $urandom; rs2 = $urandom; v32 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({val32, rd32, zr32, ill32, rdy32} !== {1'b1, 32'd5, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b rd=%h zr=%b ill=%b rdy=%b want v=1 rd=5 zr=0 ill=0 rdy=0",
                 i, val32, rd32, zr32, ill32, rdy32);
      end
    end
    v32 = 1'b0; rdy_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy32, val32} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", rdy32, val32);
    end
    @(posedge clk); #1;
    checks++;
    if (val32 !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_phantom got v=%b want v=0", val32);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic zr, ill; int lat; bit bok;
    logic [4:0] o;
    for (int i = 0; i < 4; i++) begin
      o = (i == 0) ? 5'b01011 : (i == 1) ? 5'b00110 : 5'($urandom_range(24, 31));
      do_op(0, o, $urandom, $urandom, rd, zr, ill, lat, bok);
      checks++;
      if ({rd, zr, ill} !== {32'h0, 1'b1, 1'b1} || lat != 1) begin
        errors++;
        $display("FAIL illegal op=%b got rd=%h zr=%b ill=%b lat=%0d want rd=0 zr=1 ill=1 lat=1",
                 o, rd, zr, ill, lat);
      end
    end
  endtask

  task automatic test_no_muldiv();
    logic [31:0] rd; logic zr, ill; int lat; bit bok;
    do_op(1, 5'b10000, 32'd3, 32'd5, rd, zr, ill, lat, bok);
    checks++;
    if ({rd, zr, ill} !== {32'h0, 1'b1, 1'b1} || lat != 1) begin
      errors++;
      $display("FAIL nomd_mul got rd=%h zr=%b ill=%b lat=%0d want rd=0 zr=1 ill=1 lat=1", rd, zr, ill, lat);
    end
    do_op(1, 5'b00010, 32'd2, 32'd2, rd, zr, ill, lat, bok);
    checks++;
    if ({rd, zr, ill} !== {32'd4, 1'b0, 1'b0} || lat != 1) begin
      errors++;
      $display("FAIL nomd_sum got rd=%h zr=%b ill=%b lat=%0d want rd=4 zr=0 ill=0 lat=1", rd, zr, ill, lat);
    end
  endtask

  task automatic test_xlen16();
    logic [31:0] rd, a, b; logic zr, ill; int lat, elat; bit bok;
    logic [4:0] o; logic [32:0] m;
    do_op(2, 5'b10000, 32'h00FF, 32'h0101, rd, zr, ill, lat, bok);
    checks++;
    if ({rd, ill} !== {32'h0000FFFF, 1'b0} || lat != 17) begin
      errors++;
      $display("FAIL x16_mul got rd=%h ill=%b lat=%0d want rd=ffff ill=0 lat=17", rd, ill, lat);
    end
    for (int i = 0; i < 12; i++) begin
      o = 5'($urandom_range(0, 23));
      a = $urandom; b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      m = model(16, o, a, b, 1'b1);
      elat = (o >= 5'd16) ? 17 : 1;
      do_op(2, o, a, b, rd, zr, ill, lat, bok);
      checks++;
      if ({ill, zr, rd} !== {m[32], m[31:0] == 32'h0, m[31:0]} || lat != elat) begin
        errors++;
        $display("FAIL x16_rand op=%b a=%h b=%h got rd=%h zr=%b ill=%b lat=%0d want rd=%h ill=%b lat=%0d",
                 o, a[15:0], b[15:0], rd, zr, ill, lat, m[31:0], m[32], elat);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic zr, ill; int lat; bit bok, seen;
    op = 5'b10100; rs1 = 32'd1000; rs2 = 32'd7; v32 = 1'b1;
    @(posedge clk); #1; v32 = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({val32, rd32, zr32, ill32} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async got v=%b rd=%h zr=%b ill=%b want v=0 rd=0 zr=1 ill=0",
               val32, rd32, zr32, ill32);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got rdy=%b want 1", rdy32);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (val32 !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_stale got valid_seen=1 want 0");
    end
    do_op(0, 5'b00010, 32'd2, 32'd3, rd, zr, ill, lat, bok);
    checks++;
    if ({rd, zr, ill} !== {32'd5, 1'b0, 1'b0} || lat != 1) begin
      errors++;
      $display("FAIL rstmid_sum got rd=%h zr=%b ill=%b lat=%0d want rd=5 zr=0 ill=0 lat=1", rd, zr, ill, lat);
    end
  endtask

  initial begin
    rst = 1'b1; op = '0; rs1 = '0; rs2 = '0; rdy_i = 1'b1;
    v32 = 1'b0; vnm = 1'b0; v16 = 1'b0;
    test_reset();
    test_legacy_directed();
    test_legacy_random();
    test_muldiv_directed();
    test_muldiv_random();
    test_backpressure();
    test_illegal();
    test_no_muldiv();
    test_xlen16();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
